// File: rtl/shr_words.sv
// Multi-word one-bit right shift (divide by two), word 0 most significant.
// One word per READ/WRITE pair, so in-place operation on a single memory is safe.
module shr_words #(
    parameter int OPW = 32,
    parameter int ADW = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [ADW-1:0] length,
    input  logic           carry_in,
    output logic           ready,
    output logic           carry_out,
    output logic [ADW-1:0] opa_rd_addr,
    input  logic [OPW-1:0] opa_rd_data,
    output logic [ADW-1:0] opr_wr_addr,
    output logic [OPW-1:0] opr_wr_data,
    output logic           opr_wr_we
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADW-1:0] ONE = ADW'(1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [ADW-1:0] r_index;
    logic [ADW-1:0] r_len;
    logic           r_carry;
    logic           r_carry_out;
    logic           w_start_acc;
    logic           w_last;

    function automatic logic [OPW-1:0] shr1(input logic cin, input logic [OPW-1:0] word);
        return {cin, word[OPW-1:1]};
    endfunction

    assign w_start_acc = start && (r_state == S_IDLE);
    assign w_last      = (r_index == (r_len - ONE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) begin
                    w_state_nxt = (length == '0) ? S_DONE : S_READ;
                end
            end
            S_READ:  w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = w_last ? S_DONE : S_READ;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Index, length and carry only change on an accepted start or in WRITE/DONE,
    // so a start seen while busy cannot disturb a running shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_index     <= '0;
            r_len       <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_index <= '0;
                r_len   <= length;
                r_carry <= carry_in;
            end else if (r_state == S_WRITE) begin
                r_carry <= opa_rd_data[0];
                if (!w_last) begin
                    r_index <= r_index + ONE;
                end
            end
            if (r_state == S_DONE) begin
                r_carry_out <= r_carry;
            end
        end
    end

    always_comb begin
        ready       = (r_state == S_IDLE);
        carry_out   = r_carry_out;
        opa_rd_addr = '0;
        opr_wr_addr = '0;
        opr_wr_data = '0;
        opr_wr_we   = 1'b0;
        case (r_state)
            S_READ: begin
                opa_rd_addr = r_index;
            end
            S_WRITE: begin
                opr_wr_we   = 1'b1;
                opr_wr_addr = r_index;
                opr_wr_data = shr1(r_carry, opa_rd_data);
            end
            default: begin
                opa_rd_addr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_shr_words.sv
// Bench for shr_words: one shared source/result memory (in-place), write log,
// and a reference model treating the operand as one wide integer.
module tb_shr_words;
    localparam int OPW = 32;
    localparam int ADW = 8;

    logic           clk;
    logic           reset_n;
    logic           start;
    logic [ADW-1:0] length;
    logic           carry_in;
    logic           ready;
    logic           carry_out;
    logic [ADW-1:0] opa_rd_addr;
    logic [OPW-1:0] opa_rd_data;
    logic [ADW-1:0] opr_wr_addr;
    logic [OPW-1:0] opr_wr_data;
    logic           opr_wr_we;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [OPW-1:0] mem [256];
    logic [OPW-1:0] rd_q;
    logic [OPW-1:0] exp_mem [256];
    logic           exp_carry;
    int             wr_cyc [$];
    int             wr_adr [$];
    logic [OPW-1:0] wr_dat [$];

    shr_words #(.OPW(OPW), .ADW(ADW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .length(length),
        .carry_in(carry_in), .ready(ready), .carry_out(carry_out),
        .opa_rd_addr(opa_rd_addr), .opa_rd_data(opa_rd_data),
        .opr_wr_addr(opr_wr_addr), .opr_wr_data(opr_wr_data), .opr_wr_we(opr_wr_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign opa_rd_data = rd_q;

    // Synchronous-read memory shared by source and result; every write is logged with its cycle.
    always @(posedge clk) begin
        rd_q <= mem[opa_rd_addr];
        if (opr_wr_we === 1'b1) begin
            mem[opr_wr_addr] = opr_wr_data;
            wr_cyc.push_back(cyc);
            wr_adr.push_back(int'(opr_wr_addr));
            wr_dat.push_back(opr_wr_data);
        end
    end

    // Reference: concatenate words (word 0 on top), shift the whole integer right, carry_in enters at the top.
    task automatic model(input int n, input logic cin);
        logic [8191:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[(n-1-i)*OPW +: OPW] = mem[i];
        exp_carry = (n == 0) ? cin : v[0];
        v = v >> 1;
        if (n > 0) v[n*OPW-1] = cin;
        for (int i = 0; i < n; i++) exp_mem[i] = v[(n-1-i)*OPW +: OPW];
    endtask

    task automatic start_op(input int n, input logic cin, output int t);
        @(negedge clk);
        wr_cyc.delete(); wr_adr.delete(); wr_dat.delete();
        start = 1'b1; length = ADW'(n); carry_in = cin;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready(output bit to);
        int k = 0;
        to = 1'b0;
        while (ready !== 1'b1) begin
            if (k >= 700) begin to = 1'b1; break; end
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ready); end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL rst_carry got %b want 0", carry_out); end
        checks++; if (opr_wr_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", opr_wr_we); end
        checks++; if (opa_rd_addr !== '0) begin errors++; $display("FAIL rst_rdaddr got %h want 0", opa_rd_addr); end
        checks++; if (opr_wr_addr !== '0) begin errors++; $display("FAIL rst_wraddr got %h want 0", opr_wr_addr); end
        checks++; if (opr_wr_data !== '0) begin errors++; $display("FAIL rst_wrdata got %h want 0", opr_wr_data); end
    endtask

    task automatic test_single_word;
        int t; bit to;
        mem[0] = 32'h0000_0003;
        start_op(1, 1'b1, t);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL one_busy got %b want 0", ready); end
        wait_ready(to);
        checks++; if (to) begin errors++; $display("FAIL one_timeout got 1 want 0"); end
        checks++; if (cyc !== t + 4) begin errors++; $display("FAIL one_ready_cyc got %0d want %0d", cyc - t, 4); end
        checks++; if (wr_cyc.size() !== 1) begin errors++; $display("FAIL one_nwr got %0d want 1", wr_cyc.size()); end
        if (wr_cyc.size() >= 1) begin
            checks++; if (wr_cyc[0] !== t + 2 || wr_adr[0] !== 0 || wr_dat[0] !== 32'h8000_0001) begin
                errors++; $display("FAIL one_write got %h@%0d c%0d want 80000001@0 c2", wr_dat[0], wr_adr[0], wr_cyc[0] - t);
            end
        end
        checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL one_carry got %b want 1", carry_out); end
    endtask

    task automatic test_two_words;
        int t; bit to;
        mem[0] = 32'h0000_0001; mem[1] = 32'h0000_0000;
        start_op(2, 1'b0, t);
        wait_ready(to);
        checks++; if (to || cyc !== t + 6) begin errors++; $display("FAIL two_ready_cyc got %0d want 6", cyc - t); end
        checks++; if (wr_cyc.size() !== 2) begin errors++; $display("FAIL two_nwr got %0d want 2", wr_cyc.size()); end
        if (wr_cyc.size() == 2) begin
            checks++; if (wr_dat[0] !== 32'h0 || wr_adr[0] !== 0 || wr_cyc[0] !== t + 2) begin
                errors++; $display("FAIL two_w0 got %h@%0d want 00000000@0", wr_dat[0], wr_adr[0]);
            end
            checks++; if (wr_dat[1] !== 32'h8000_0000 || wr_adr[1] !== 1 || wr_cyc[1] !== t + 4) begin
                errors++; $display("FAIL two_w1 got %h@%0d want 80000000@1", wr_dat[1], wr_adr[1]);
            end
        end
        checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL two_carry got %b want 0", carry_out); end
    endtask

    task automatic test_zero_length;
        int t; bit to;
        start_op(0, 1'b1, t);
        wait_ready(to);
        checks++; if (to || cyc !== t + 2) begin errors++; $display("FAIL zero_ready_cyc got %0d want 2", cyc - t); end
        checks++; if (wr_cyc.size() !== 0) begin errors++; $display("FAIL zero_nwr got %0d want 0", wr_cyc.size()); end
        checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL zero_carry got %b want 1", carry_out); end
    endtask

    task automatic test_max_length;
        int t; bit to; int bad;
        for (int i = 0; i < 255; i++) mem[i] = 32'hFFFF_FFFF;
        mem[255] = 32'h1234_5678;
        start_op(255, 1'b0, t);
        wait_ready(to);
        checks++; if (to || cyc !== t + 512) begin errors++; $display("FAIL max_ready_cyc got %0d want 512", cyc - t); end
        checks++; if (wr_cyc.size() !== 255) begin errors++; $display("FAIL max_nwr got %0d want 255", wr_cyc.size()); end
        checks++; if (mem[0] !== 32'h7FFF_FFFF) begin errors++; $display("FAIL max_w0 got %h want 7fffffff", mem[0]); end
        bad = 0;
        for (int i = 1; i < 255; i++) if (mem[i] !== 32'hFFFF_FFFF) bad++;
        for (int k = 0; k < wr_cyc.size(); k++) if (wr_cyc[k] !== t + 2 + 2*k || wr_adr[k] !== k) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL max_words got %0d bad want 0", bad); end
        checks++; if (mem[255] !== 32'h1234_5678) begin errors++; $display("FAIL max_nowrap got %h want 12345678", mem[255]); end
        checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL max_carry got %b want 1", carry_out); end
    endtask

    task automatic test_busy_start;
        int t; bit to; int bad; logic cin;
        for (int i = 0; i < 4; i++) mem[i] = $urandom;
        cin = 1'($urandom);
        model(4, cin);
        start_op(4, cin, t);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; length = ADW'(1); carry_in = ~cin;
        @(negedge clk);
        start = 1'b0;
        wait_ready(to);
        checks++; if (to || cyc !== t + 10) begin errors++; $display("FAIL busy_ready_cyc got %0d want 10", cyc - t); end
        checks++; if (wr_cyc.size() !== 4) begin errors++; $display("FAIL busy_nwr got %0d want 4", wr_cyc.size()); end
        bad = 0;
        for (int k = 0; k < wr_cyc.size(); k++)
            if (wr_cyc[k] !== t + 2 + 2*k || wr_adr[k] !== k || wr_dat[k] !== exp_mem[k]) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL busy_writes got %0d bad want 0", bad); end
        checks++; if (carry_out !== exp_carry) begin errors++; $display("FAIL busy_carry got %b want %b", carry_out, exp_carry); end
    endtask

    task automatic test_random_shifts;
        int t; bit to; int bad; int n; logic cin;
        for (int it = 0; it < 10; it++) begin
            n = (it == 9) ? int'($urandom_range(100, 200)) : int'($urandom_range(1, 24));
            cin = 1'($urandom);
            for (int i = 0; i < n; i++) mem[i] = (it % 3 == 0) ? {$urandom_range(0, 3)} : $urandom;
            model(n, cin);
            start_op(n, cin, t);
            wait_ready(to);
            checks++; if (to || cyc !== t + 2*n + 2) begin errors++; $display("FAIL rnd%0d_ready_cyc got %0d want %0d", it, cyc - t, 2*n + 2); end
            bad = (wr_cyc.size() !== n) ? 1 : 0;
            for (int k = 0; k < wr_cyc.size(); k++)
                if (wr_cyc[k] !== t + 2 + 2*k || wr_adr[k] !== k || wr_dat[k] !== exp_mem[k]) bad++;
            for (int i = 0; i < n; i++) if (mem[i] !== exp_mem[i]) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL rnd%0d_data got %0d bad want 0 (n=%0d)", it, bad, n); end
            checks++; if (carry_out !== exp_carry) begin errors++; $display("FAIL rnd%0d_carry got %b want %b", it, carry_out, exp_carry); end
        end
    endtask

    task automatic test_reset_abort;
        int t; bit to; logic cin; int last;
        mem[0] = 32'h0000_0001;
        start_op(1, 1'b0, t);
        wait_ready(to);
        checks++; if (to || carry_out !== 1'b1) begin errors++; $display("FAIL abort_pre_carry got %b want 1", carry_out); end
        for (int i = 0; i < 4; i++) mem[i] = $urandom;
        start_op(4, 1'b1, t);
        while (cyc < t + 5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1 || carry_out !== 1'b0 || opr_wr_we !== 1'b0) begin
            errors++; $display("FAIL abort_immediate got rdy=%b co=%b we=%b want 1 0 0", ready, carry_out, opr_wr_we);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        last = (wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] - t : -1;
        checks++; if (wr_cyc.size() !== 2 || last !== 4) begin
            errors++; $display("FAIL abort_writes got %0d writes last c%0d want 2 last c4", wr_cyc.size(), last);
        end
        mem[0] = $urandom;
        cin = 1'($urandom);
        model(1, cin);
        start_op(1, cin, t);
        wait_ready(to);
        checks++; if (to || cyc !== t + 4) begin errors++; $display("FAIL abort_new_ready got %0d want 4", cyc - t); end
        checks++; if (wr_cyc.size() !== 1 || mem[0] !== exp_mem[0]) begin
            errors++; $display("FAIL abort_new_data got %h want %h", mem[0], exp_mem[0]);
        end
        checks++; if (carry_out !== exp_carry) begin errors++; $display("FAIL abort_new_carry got %b want %b", carry_out, exp_carry); end
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        length   = '0;
        carry_in = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        test_reset;
        reset_n = 1'b1;
        @(negedge clk);
        test_single_word;
        test_two_words;
        test_zero_length;
        test_max_length;
        test_busy_start;
        test_random_shifts;
        test_reset_abort;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shr_words.md
SHR_WORDS -- requirements
Module: shr_words

Interface
REQ-001 Parameter OPW, default 32, SHALL set the operand word width in bits (OPW >= 2).
REQ-002 Parameter ADW, default 8, SHALL set the word address and length width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle request to begin a shift; sampled only while ready=1.
REQ-006 length  input  ADW  SHALL give the number of operand words; sampled when start is accepted.
REQ-007 carry_in  input  1  SHALL give the bit shifted into the MSB of word 0; sampled when start is accepted.
REQ-008 ready  output  1  SHALL be 1 when idle and able to accept start.
REQ-009 carry_out  output  1  SHALL give the bit shifted out of the LSB of the last word, valid when ready=1.
REQ-010 opa_rd_addr  output  ADW  SHALL be the source memory read address; read data arrives one cycle later.
REQ-011 opa_rd_data  input  OPW  SHALL be the source memory read data.
REQ-012 opr_wr_addr  output  ADW  SHALL be the result memory write address.
REQ-013 opr_wr_data  output  OPW  SHALL be the result memory write data.
REQ-014 opr_wr_we  output  1  SHALL be the result memory write enable, one cycle per word.

Function
REQ-015 The block SHALL perform a one-bit right shift (divide by 2) of a multi-word operand; word 0 is most significant, word length-1 is least significant.
REQ-016 FSM states SHALL be IDLE, READ, WRITE, DONE; IDLE->READ on accepted start with length!=0; IDLE->DONE on accepted start with length=0.
REQ-017 In READ the block SHALL drive opa_rd_addr=index, then go to WRITE.
REQ-018 In WRITE the block SHALL drive opr_wr_we=1, opr_wr_addr=index, opr_wr_data={carry_reg, opa_rd_data[OPW-1:1]} and update carry_reg<=opa_rd_data[0].
REQ-019 From WRITE, if index=length_reg-1 the block SHALL go to DONE; otherwise it SHALL increment index and go to READ.
REQ-020 DONE SHALL last one cycle, copy carry_reg to carry_out, and return to IDLE.
REQ-021 carry_reg SHALL load carry_in and index SHALL load 0 when start is accepted.
REQ-022 With start accepted at cycle T: ready=0 from T+1; the k-th write (k=0..n-1) SHALL occur at T+2+2k; ready=1 again at T+2n+2. For n=0: no writes, ready=1 at T+2.
REQ-023 start while ready=0 SHALL be ignored with no effect on state, index, length_reg or carry.
REQ-024 opr_wr_we SHALL be 0 in every state except WRITE; opr_wr_addr and opr_wr_data SHALL be don't-care when opr_wr_we=0.
REQ-025 In-place operation (source and result as the same memory) SHALL be correct, because each word is read before it is written.
REQ-026 length=2^ADW-1 SHALL be supported; index SHALL never wrap past length_reg-1.
REQ-027 carry_out SHALL hold its value from DONE until the next DONE.

Reset
REQ-028 On reset_n=0 the block SHALL go to IDLE immediately, with ready=1, carry_out=0, opr_wr_we=0, opa_rd_addr=0, opr_wr_addr=0, opr_wr_data=0, index=0 and carry_reg=0.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no further writes; after release the block SHALL accept a new start.

Verification
REQ-030 n=1, word0=0x00000003, carry_in=1 -> write 0x80000001 at addr 0 at T+2; carry_out=1 and ready=1 at T+4.
REQ-031 n=2, words {0x00000001, 0x00000000}, carry_in=0 -> writes 0x00000000@0, then 0x80000000@1; carry_out=0.
REQ-032 n=0, start -> no opr_wr_we pulse; ready=1 at T+2; carry_out=carry_in.
REQ-033 n=255, all words 0xFFFFFFFF, carry_in=0 -> word0=0x7FFFFFFF, words 1..254=0xFFFFFFFF, carry_out=1; ready at T+512.
REQ-034 n=4, start pulsed again at T+3 with length=1 -> ignored; all four writes occur at the REQ-022 cycles.
REQ-035 n=4, reset_n pulsed low at T+5 -> no writes after the reset, ready=1 and carry_out=0 immediately; a new n=1 start completes correctly.
